addsub_32_reg: RTL and testbench
================================

Name: addsub_32_reg

Overview:
- 32-bit two's-complement adder/subtractor with registered outputs; the datapath primitive for ALU add/sub/compare paths.
- S = X + Y when sub = 0 and S = X − Y when sub = 1. Subtraction is computed as X + ~Y + 1.
- Carry-lookahead structure: 4-bit CLA groups chained by group carry.
- One-cycle latency, valid-qualified.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 4 (one CLA group per 4 bits).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- x  input  WIDTH  operand X
- y  input  WIDTH  operand Y
- sub  input  1  0 = add, 1 = subtract
- s  output  WIDTH  registered result
- cout  output  1  registered carry out of MSB (subtract: 1 = no borrow)
- out_valid  output  1  s/cout (and flags) valid

Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Operand preparation: yb = y XOR {WIDTH{sub}}; carry-in c0 = sub.
- CLA group g, bits 4g..4g+3:
  - per-bit p = x^yb, gen = x&yb;
  - internal carries c[i+1] = gen[i] | p[i]&c[i], in lookahead (flattened) form within the group;
  - group P/G produced; group carry-out feeds the next group.
- Sum bit s[i] = p[i] ^ c[i]. cout = carry out of bit WIDTH−1.
- Arithmetic is modulo 2^WIDTH; wrap-around is silent, and cout reports it.
  - Add: cout = 1 means unsigned overflow.
  - Subtract: cout = 1 means x ≥ y (unsigned), 0 means borrow.
- Registering:
  - On the rising clk edge with in_valid = 1: capture s and cout; out_valid <= 1.
  - With in_valid = 0: s/cout hold their last value; out_valid <= 0.
- Latency: exactly 1 cycle. Back-to-back in_valid every cycle is supported with full throughput. No backpressure.
- Reset (rst_n = 0, asynchronous): s = 0, cout = 0, out_valid = 0 immediately, regardless of clk.
  - A transaction in flight at reset assertion is discarded.
  - The first capture after deassertion occurs on the first rising edge with rst_n = 1 and in_valid = 1.
- sub is sampled with the operands on the same edge. Changing sub between cycles has no effect on earlier results.
- x/y/sub values while in_valid = 0 are don't-care and must not affect the outputs.

Optional Feature:
- Macro ADDSUB_32_FLAGS_EN.
- When defined, three extra registered output ports (1 bit each) are added, captured with s and reset to 0:
  - ovf = c[WIDTH] ^ c[WIDTH−1] (signed overflow);
  - zero = (result == 0);
  - neg = result[WIDTH−1].
- When undefined, these ports and their logic are absent. s/cout/out_valid behaviour is identical in both builds.

Test Plan:
- x=136, y=17, sub=1, in_valid=1 -> next cycle: s=119 (0x77), cout=1, out_valid=1. With flags build: ovf=0, zero=0, neg=0.
- x=0xFFFFFFFF, y=0xFFFFFFFE, sub=1 -> s=0x00000001, cout=1.
- x=0xFFFFFFFF, y=0x00000001, sub=0 -> s=0x00000000, cout=1 (wrap). With flags build: zero=1, ovf=0.
- x=0x7FFFFFFF, y=1, sub=0 -> s=0x80000000, cout=0. With flags build: ovf=1, neg=1.
- Other input cases:
  - x=5, y=9, sub=1 -> s=0xFFFFFFFC, cout=0 (borrow).
  - Four back-to-back valid operations -> four results on consecutive cycles, in order.
  - A cycle with in_valid=0 -> out_valid=0 and s holds.
- Assert rst_n=0 between clock edges while out_valid=1 -> s=0, cout=0, out_valid=0 immediately. After release, no output until the next in_valid.

Source files
------------

// File: rtl/addsub_32_reg.sv
// Registered two's-complement adder/subtractor built from 4-bit CLA groups.
// Optional flag outputs (ovf/zero/neg) are enabled with ADDSUB_32_FLAGS_EN.
module addsub_32_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
`ifdef ADDSUB_32_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int NGRP = WIDTH / 4;

  logic [WIDTH-1:0] yb;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP-1:0]  grp_g;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             vld_d, vld_q;

  // Operand prep, per-group lookahead carries, and the sum
  always_comb begin
    yb    = y ^ {WIDTH{sub}};
    p     = x ^ yb;
    g     = x & yb;
    c     = '0;
    grp_p = '0;
    grp_g = '0;
    c[0]  = sub;
    for (int k = 0; k < NGRP; k++) begin
      c[4*k+1] = g[4*k]
               | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k]
                  & c[4*k]);
      grp_p[k] = p[4*k+3] & p[4*k+2]
               & p[4*k+1] & p[4*k];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1]
                  & g[4*k]);
      c[4*k+4] = grp_g[k] | (grp_p[k] & c[4*k]);
    end
    sum = p ^ c[WIDTH-1:0];
  end

  // Capture on valid, hold otherwise
  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    vld_d  = in_valid;
    if (in_valid) begin
      s_d    = sum;
      cout_d = c[WIDTH];
    end
  end

  // Result registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;

`ifdef ADDSUB_32_FLAGS_EN
  logic ovf_d, ovf_q;
  logic zero_d, zero_q;
  logic neg_d, neg_q;

  // Signed overflow, zero and sign flags of the new result
  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    if (in_valid) begin
      ovf_d  = c[WIDTH] ^ c[WIDTH-1];
      zero_d = (sum == '0);
      neg_d  = sum[WIDTH-1];
    end
  end

  // Flag registers, cleared with the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign neg  = neg_q;
`endif

endmodule

// File: tb/tb_addsub_32_reg.sv
// Directed bench for addsub_32_reg.
// Flag checks compile in when ADDSUB_32_FLAGS_EN is defined.
module tb_addsub_32_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] x;
  logic [31:0] y;
  logic        sub;
  logic [31:0] s;
  logic        cout;
  logic        out_valid;
`ifdef ADDSUB_32_FLAGS_EN
  logic        ovf;
  logic        zero;
  logic        neg;
`endif

  int total = 0;
  int bad   = 0;

  addsub_32_reg #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .x        (x),
    .y        (y),
    .sub      (sub),
    .s        (s),
    .cout     (cout),
    .out_valid(out_valid)
`ifdef ADDSUB_32_FLAGS_EN
    ,
    .ovf      (ovf),
    .zero     (zero),
    .neg      (neg)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] xi,
                       input logic [31:0] yi,
                       input logic si);
    in_valid = v;
    x        = xi;
    y        = yi;
    sub      = si;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic [31:0] es,
                         input logic ec,
                         input logic ev);
    chk({tag, ".s"}, s, es);
    chk({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, ".vld"}, {31'd0, out_valid},
        {31'd0, ev});
  endtask

`ifdef ADDSUB_32_FLAGS_EN
  task automatic chk_flg(input string tag,
                         input logic eo,
                         input logic ez,
                         input logic en);
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    chk({tag, ".neg"}, {31'd0, neg}, {31'd0, en});
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 32'h1234_5678, 32'h1, 1'b0);
    #3;
    chk_out("rst", 32'h0, 1'b0, 1'b0);
    tick();
    chk_out("rst_clk", 32'h0, 1'b0, 1'b0);
`ifdef ADDSUB_32_FLAGS_EN
    chk_flg("rst", 1'b0, 1'b0, 1'b0);
`endif
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #3;
    rst_n = 1'b1;

    drive(1'b1, 32'd136, 32'd17, 1'b1);
    tick();
    chk_out("sub136", 32'd119, 1'b1, 1'b1);
`ifdef ADDSUB_32_FLAGS_EN
    chk_flg("sub136", 1'b0, 1'b0, 1'b0);
`endif

    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    tick();
    chk_out("subff", 32'h1, 1'b1, 1'b1);

    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0);
    tick();
    chk_out("wrap", 32'h0, 1'b1, 1'b1);
`ifdef ADDSUB_32_FLAGS_EN
    chk_flg("wrap", 1'b0, 1'b1, 1'b0);
`endif

    drive(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0);
    tick();
    chk_out("sovf", 32'h8000_0000, 1'b0, 1'b1);
`ifdef ADDSUB_32_FLAGS_EN
    chk_flg("sovf", 1'b1, 1'b0, 1'b1);
`endif

    drive(1'b1, 32'd5, 32'd9, 1'b1);
    tick();
    chk_out("borrow", 32'hFFFF_FFFC, 1'b0, 1'b1);
`ifdef ADDSUB_32_FLAGS_EN
    chk_flg("borrow", 1'b0, 1'b0, 1'b1);
`endif

    drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0);
    tick();
    chk_out("b2b0", 32'h2345_6789, 1'b0, 1'b1);
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    tick();
    chk_out("b2b1", 32'h0, 1'b1, 1'b1);
    drive(1'b1, 32'h0000_FFFF, 32'h1, 1'b0);
    tick();
    chk_out("b2b2", 32'h0001_0000, 1'b0, 1'b1);
    drive(1'b1, 32'h0001_0000, 32'h1, 1'b1);
    tick();
    chk_out("b2b3", 32'h0000_FFFF, 1'b1, 1'b1);

    drive(1'b0, 32'hDEAD_BEEF, 32'h1, 1'b1);
    tick();
    chk_out("idle0", 32'h0000_FFFF, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    tick();
    chk_out("idle1", 32'h0000_FFFF, 1'b1, 1'b0);

    drive(1'b1, 32'd3, 32'd4, 1'b0);
    tick();
    chk_out("pre_rst", 32'd7, 1'b0, 1'b1);
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst", 32'h0, 1'b0, 1'b0);
    tick();
    chk_out("arst_hold", 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h5, 32'h5, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    chk_out("post_rst", 32'h0, 1'b0, 1'b0);

    drive(1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0);
    tick();
    chk_out("post_op", 32'hFFFF_FFFF, 1'b0, 1'b1);
`ifdef ADDSUB_32_FLAGS_EN
    chk_flg("post_op", 1'b0, 1'b0, 1'b1);
`endif

    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
